fetch_sequencer: RTL



---
 rtl/fetch_sequencer_if.sv | 32 +++
 rtl/fetch_sequencer.sv | 85 ++++++++
 2 files changed

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: bundles the core, loader, memory and delivery signals of the fetch sequencer
interface fetch_sequencer_if #(
    parameter int AW = 6,
    parameter int DW = 32
);
    logic          run;
    logic          stall;
    logic          jmp_valid;
    logic [AW-1:0] jmp_addr;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_ack;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          wrap;

    modport slave (
        input  run, stall, jmp_valid, jmp_addr, ld_req, ld_addr, ld_data, mem_rdata,
        output ld_ack, mem_addr, mem_we, mem_wdata, instr, instr_pc, instr_valid, wrap
    );

    modport master (
        output run, stall, jmp_valid, jmp_addr, ld_req, ld_addr, ld_data, mem_rdata,
        input  ld_ack, mem_addr, mem_we, mem_wdata, instr, instr_pc, instr_valid, wrap
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the pc, issues instruction fetches and gives the loader priority on the memory port
module fetch_sequencer #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input logic             clk,
    input logic             rst,
    fetch_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, LOAD} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_pc;
    logic          r_inflight;
    logic [AW-1:0] r_inflight_pc;
    logic [DW-1:0] r_instr;
    logic [AW-1:0] r_instr_pc;
    logic          r_instr_valid;
    logic          r_wrap;
    logic          w_issue;
    logic          w_jump;
    logic          w_load_end;
    logic          w_capture;

    // state register
    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_next;
    end

    // loader always wins, otherwise run decides between fetching and idling
    always_comb begin
        w_next = bus.ld_req ? LOAD : (bus.run ? FETCH : IDLE);
    end

    // memory grant and per-cycle control decisions; a jump kills the read launched last cycle
    always_comb begin
        w_jump        = bus.jmp_valid & !bus.ld_req;
        w_issue       = !bus.ld_req & bus.run & !bus.stall & !bus.jmp_valid;
        w_load_end    = (r_state == LOAD) & !bus.ld_req;
        w_capture     = r_inflight & !w_jump;
        bus.ld_ack    = bus.ld_req & !rst;
        bus.mem_we    = bus.ld_req & !rst;
        bus.mem_addr  = bus.ld_req ? bus.ld_addr : r_pc;
        bus.mem_wdata = bus.ld_data;
    end

    // program counter: jump beats end-of-load rewind, which beats sequential advance
    always_ff @(posedge clk) begin
        if (rst)
            r_pc <= '0;
        else if (w_jump)
            r_pc <= bus.jmp_addr;
        else if (w_load_end)
            r_pc <= '0;
        else if (w_issue)
            r_pc <= r_pc + AW'(1);
    end

    // two-stage fetch pipeline: track the launched read, then capture its data and tag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_wrap        <= 1'b0;
        end else begin
            r_inflight    <= w_issue;
            r_inflight_pc <= r_pc;
            r_instr_valid <= w_capture;
            r_wrap        <= w_issue & (r_pc == '1);
            if (w_capture) begin
                r_instr    <= bus.mem_rdata;
                r_instr_pc <= r_inflight_pc;
            end
        end
    end

    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_instr_valid;
    assign bus.wrap        = r_wrap;
endmodule
